pipe_cla_adder: RTL and testbench

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

---
 rtl/pipe_cla_adder.sv | 156 +++++++++++++++
 tb/tb_pipe_cla_adder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_cla_adder.sv
// Pipelined signed adder/subtractor: one SEG-bit carry-lookahead segment per stage.
// Define PIPE_CLA_SAT_EN to saturate sum on signed overflow instead of wrapping.
module pipe_cla_adder #(
  parameter int N   = 32,
  parameter int SEG = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         ovf,
  output logic         cout
);

  localparam int S = N / SEG;
  localparam logic [N-1:0] SEG_MASK = N'({SEG{1'b1}});
  localparam logic [N-1:0] SAT_MAX  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN  = {1'b1, {(N-1){1'b0}}};

  if ((N < 4) || ((N % SEG) != 0)) begin : g_bad_cfg
    $error("pipe_cla_adder: N must be >= 4 and a multiple of SEG");
  end

  // Returns {carry_out, sum} of one segment; every carry is a flat lookahead term.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           cin);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           pp;
    g    = x & y;
    p    = x ^ y;
    c    = {(SEG+1){1'b0}};
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  // Rotate right by one segment: consumed operand segment leaves, result segment enters on top.
  function automatic logic [N-1:0] rotr_seg(input logic [N-1:0] x);
    return (x >> SEG) | (x << (N - SEG));
  endfunction

  logic adv_s;

  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  for (genvar k = 0; k < S; k++) begin : g_stg
    localparam int BW = N - k * SEG;

    logic [N-1:0]  wi_s;
    logic [BW-1:0] bi_s;
    logic          ci_s;
    logic          vi_s;
    logic [SEG:0]  r_s;
    logic [N-1:0]  wn_s;
    logic [N-1:0]  wd_s;
    logic          v_r;
    logic          c_r;
    logic [N-1:0]  w_r;

    if (k == 0) begin : g_src
      assign wi_s = a;
      assign bi_s = sub ? ~b : b;
      assign ci_s = sub;
      assign vi_s = in_valid;
    end else begin : g_src
      assign wi_s = g_stg[k-1].w_r;
      assign bi_s = g_stg[k-1].g_mid.bw_r;
      assign ci_s = g_stg[k-1].c_r;
      assign vi_s = g_stg[k-1].v_r;
    end

    assign r_s  = cla_seg(wi_s[SEG-1:0], bi_s[SEG-1:0], ci_s);
    assign wn_s = rotr_seg((wi_s & ~SEG_MASK) | N'(r_s[SEG-1:0]));

    if (k == S - 1) begin : g_fin
      logic         ovf_s;
      logic         ovf_r;
      logic [N-1:0] res_s;

      // Overflow = carry into MSB (recovered from MSB sum bit) xor carry out.
      always_comb begin
        ovf_s = r_s[SEG] ^ (wi_s[SEG-1] ^ bi_s[SEG-1] ^ r_s[SEG-1]);
`ifdef PIPE_CLA_SAT_EN
        if (ovf_s) begin
          res_s = r_s[SEG] ? SAT_MIN : SAT_MAX;
        end else begin
          res_s = wn_s;
        end
`else
        res_s = wn_s;
`endif
      end

      assign wd_s = res_s;

      // Overflow flag register, aligned with the final result stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (adv_s) begin
          ovf_r <= ovf_s;
        end
      end
    end else begin : g_mid
      logic [BW-SEG-1:0] bw_r;

      assign wd_s = wn_s;

      // Skew register for the not-yet-consumed B segments.
      always_ff @(posedge clk) begin
        if (rst) begin
          bw_r <= {(BW-SEG){1'b0}};
        end else if (adv_s) begin
          bw_r <= bi_s[BW-1:SEG];
        end
      end
    end

    // Stage register: valid, segment carry, and the merged A/result word.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        w_r <= {N{1'b0}};
      end else if (adv_s) begin
        v_r <= vi_s;
        c_r <= r_s[SEG];
        w_r <= wd_s;
      end
    end
  end

  assign out_valid = g_stg[S-1].v_r;
  assign sum       = g_stg[S-1].w_r;
  assign cout      = g_stg[S-1].c_r;
  assign ovf       = g_stg[S-1].g_fin.ovf_r;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder (N=8/SEG=4 main instance, N=32/SEG=8 directed instance).
// Expectations honour PIPE_CLA_SAT_EN when the macro is defined.
module tb_pipe_cla_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       ovf;
    logic       cout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  a8 = 8'd0;
  logic [7:0]  b8 = 8'd0;
  logic        sub8 = 1'b0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [7:0]  sum8;
  logic        ovf8;
  logic        cout8;

  logic        in_valid32 = 1'b0;
  logic        in_ready32;
  logic [31:0] a32 = 32'd0;
  logic [31:0] b32 = 32'd0;
  logic        sub32 = 1'b0;
  logic        out_valid32;
  logic        out_ready32 = 1'b1;
  logic [31:0] sum32;
  logic        ovf32;
  logic        cout32;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  exp_t sb[$];
  logic [7:0] blist [8] = '{8'd0, 8'd1, 8'd27, 8'd28, 8'd127, 8'd128, 8'd129, 8'd255};

  logic       hold_chk = 1'b0;
  logic [7:0] hold_sum;
  logic       hold_ovf;
  logic       hold_cout;
  exp_t       got_e;

  always #5 clk = ~clk;

  pipe_cla_adder #(.N(8), .SEG(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .ovf(ovf8), .cout(cout8)
  );

  pipe_cla_adder #(.N(32), .SEG(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .ovf(ovf32), .cout(cout32)
  );

  function automatic exp_t golden(input logic [7:0] x, input logic [7:0] y, input logic s);
    exp_t       e;
    int         ia;
    int         ib;
    int         r;
    logic [8:0] u;
    ia = $signed(x);
    ib = $signed(y);
    r  = s ? (ia - ib) : (ia + ib);
    u  = s ? ({1'b0, x} + {1'b0, ~y} + 9'd1) : ({1'b0, x} + {1'b0, y});
    e.cout = u[8];
    e.ovf  = (r > 127) || (r < -128);
    e.sum  = r[7:0];
`ifdef PIPE_CLA_SAT_EN
    if (r > 127) e.sum = 8'h7F;
    if (r < -128) e.sum = 8'h80;
`endif
    return e;
  endfunction

  // Output side of the scoreboard plus stall-stability monitor.
  always @(negedge clk) begin
    if (hold_chk) begin
      tests++;
      assert (out_valid8 === 1'b1 && sum8 === hold_sum && ovf8 === hold_ovf && cout8 === hold_cout)
      else begin
        fails++;
        $error("FAIL stall_hold: got v=%b sum=%h ovf=%b cout=%b, expected v=1 sum=%h ovf=%b cout=%b",
               out_valid8, sum8, ovf8, cout8, hold_sum, hold_ovf, hold_cout);
      end
    end
    hold_chk = 1'b0;
    if (out_valid8 === 1'b1 && rst === 1'b0) begin
      if (out_ready8 === 1'b1) begin
        tests++;
        assert (sb.size() != 0)
        else begin
          fails++;
          $error("FAIL spurious_out: got sum=%h with empty scoreboard, expected no output", sum8);
        end
        if (sb.size() != 0) begin
          got_e = sb.pop_front();
          tests++;
          assert ({sum8, ovf8, cout8} === {got_e.sum, got_e.ovf, got_e.cout})
          else begin
            fails++;
            $error("FAIL result: got sum=%h ovf=%b cout=%b, expected sum=%h ovf=%b cout=%b",
                   sum8, ovf8, cout8, got_e.sum, got_e.ovf, got_e.cout);
          end
        end
      end else begin
        hold_chk  = 1'b1;
        hold_sum  = sum8;
        hold_ovf  = ovf8;
        hold_cout = cout8;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       out_ready8 = 1'b1;
      1:       out_ready8 = 1'($urandom_range(0, 1));
      default: out_ready8 = 1'b0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic send_exp(input logic [7:0] x, input logic [7:0] y, input logic s, input exp_t e);
    int   tries;
    logic done;
    tries = 0;
    done  = 1'b0;
    a8 = x; b8 = y; sub8 = s; in_valid8 = 1'b1;
    while (!done && tries < 200) begin
      @(negedge clk);
      if (in_ready8 === 1'b1) begin
        sb.push_back(e);
        done = 1'b1;
      end
      tick();
      tries++;
    end
    in_valid8 = 1'b0;
    tests++;
    assert (done)
    else begin
      fails++;
      $error("FAIL accept_timeout: got no in_ready in %0d cycles, expected acceptance", tries);
    end
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s);
    send_exp(x, y, s, golden(x, y, s));
  endtask

  task automatic drain(input int lim);
    int g;
    g = 0;
    while (sb.size() != 0 && g < lim) begin
      tick();
      g++;
    end
    tests++;
    assert (sb.size() == 0)
    else begin
      fails++;
      $error("FAIL drain: got %0d beats outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    int   start;
    int   n;
    exp_t e;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_flags", {30'd0, ovf8, cout8}, 32'd0);
    chk("rst_in_ready", 32'(in_ready8), 32'd1);
    chk("rst_out_valid32", 32'(out_valid32), 32'd0);
    rst = 1'b0;
    tick();

    // Latency of 2 and first result (100 + 27)
    a8 = 8'd100; b8 = 8'd27; sub8 = 1'b0; in_valid8 = 1'b1;
    chk("lat_in_ready", 32'(in_ready8), 32'd1);
    e = '{sum: 8'd127, ovf: 1'b0, cout: 1'b0};
    sb.push_back(e);
    tick();
    in_valid8 = 1'b0;
    chk("lat_early", 32'(out_valid8), 32'd0);
    tick();
    chk("lat_valid", 32'(out_valid8), 32'd1);
    chk("lat_sum", 32'(sum8), 32'd127);
    drain(10);

    // Overflow boundaries
`ifdef PIPE_CLA_SAT_EN
    send_exp(8'd100, 8'd28, 1'b0, '{sum: 8'h7F, ovf: 1'b1, cout: 1'b0});
    send_exp(8'h80, 8'd1, 1'b1, '{sum: 8'h80, ovf: 1'b1, cout: 1'b1});
`else
    send_exp(8'd100, 8'd28, 1'b0, '{sum: 8'h80, ovf: 1'b1, cout: 1'b0});
    send_exp(8'h80, 8'd1, 1'b1, '{sum: 8'h7F, ovf: 1'b1, cout: 1'b1});
`endif
    drain(10);

    // Reset with two beats in flight; a beat presented with rst is dropped
    ready_mode = 2;
    send(8'd10, 8'd20, 1'b0);
    send(8'd30, 8'd40, 1'b1);
    rst = 1'b1; a8 = 8'd5; b8 = 8'd5; in_valid8 = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid8), 32'd0);
    chk("mid_rst_sum", 32'(sum8), 32'd0);
    chk("mid_rst_flags", {30'd0, ovf8, cout8}, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready8), 32'd1);
    sb.delete();
    rst = 1'b0; in_valid8 = 1'b0; ready_mode = 0;
    tick(); tick(); tick();
    chk("post_rst_idle", 32'(out_valid8), 32'd0);
    send_exp(8'hFF, 8'hFF, 1'b0, '{sum: 8'hFE, ovf: 1'b0, cout: 1'b1});
    drain(10);

    // Full-rate stream, add pass then sub pass
    start = cyc;
    n = 0;
    for (int s = 0; s < 2; s++) begin
      for (int ia = 0; ia < 256; ia++) begin
        for (int j = 0; j < 8; j++) begin
          send(8'(ia), blist[j], 1'(s));
          n++;
        end
      end
    end
    drain(50);
    chk("throughput_cycles", 32'(cyc - start), 32'(n + 2));

    // Backpressured stream with per-beat add/sub mixing
    ready_mode = 1;
    for (int ia = 0; ia < 256; ia++) begin
      for (int j = 0; j < 8; j++) begin
        send(8'(ia), blist[j], 1'(ia[0] ^ j[0]));
      end
    end
    drain(4000);
    ready_mode = 0;
    tick();

    // 32-bit, 4-stage instance
    a32 = 32'h7FFF_FFFF; b32 = 32'd1; sub32 = 1'b0; in_valid32 = 1'b1;
    chk("w32_in_ready", 32'(in_ready32), 32'd1);
    tick();
    in_valid32 = 1'b0;
    tick(); tick();
    chk("w32_lat_early", 32'(out_valid32), 32'd0);
    tick();
    chk("w32_valid", 32'(out_valid32), 32'd1);
`ifdef PIPE_CLA_SAT_EN
    chk("w32_sum", sum32, 32'h7FFF_FFFF);
`else
    chk("w32_sum", sum32, 32'h8000_0000);
`endif
    chk("w32_flags", {30'd0, ovf32, cout32}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
